// File: rtl/rv32i_pkg.sv
// RV32I decode definitions shared by the decode stage and its immediate generator.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  // Instruction-derived part of the EX bundle; pc is held separately at XLEN width.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        illegal;
    logic [31:0] imm;
  } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and EX-side valid/ready channels of the decode stage.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);

  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;
  logic            ex_illegal;

  // The decode stage itself.
  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready,
    output if_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd,
           ex_opcode, ex_funct3, ex_funct7b5, ex_illegal
  );

  // Fetch plus EX as seen from outside the stage.
  modport master (
    output if_valid, if_instr, if_pc, ex_ready,
    input  if_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd,
           ex_opcode, ex_funct3, ex_funct7b5, ex_illegal
  );

endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; unknown opcodes yield IMM_NONE and zero.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr_i,
  output imm_type_e   imm_type_o,
  output logic [31:0] imm_o
);

  logic [6:0] opcode;
  logic       sign;

  assign opcode = instr_i[6:0];
  assign sign   = instr_i[31];

  always_comb begin
    imm_type_o = IMM_NONE;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: imm_type_o = IMM_I;
      OP_STORE:                            imm_type_o = IMM_S;
      OP_BRANCH:                           imm_type_o = IMM_B;
      OP_LUI, OP_AUIPC:                    imm_type_o = IMM_U;
      OP_JAL:                              imm_type_o = IMM_J;
      default:                             imm_type_o = IMM_NONE;
    endcase
  end

  always_comb begin
    imm_o = '0;
    unique case (imm_type_o)
      IMM_I: imm_o = {{20{sign}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{sign}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{sign}}, sign, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{sign}}, sign, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry skid between fetch and EX, driving register-file reads
// and bypassing the writeback that lands on the same edge as the read.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  decode_stage_if.slave   bus,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            flush
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e          state_q, state_d;
  decoded_t        dec_q, dec_d, dec_in;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            byp1_hit_q, byp1_hit_d, byp2_hit_q, byp2_hit_d;
  logic [XLEN-1:0] byp1_data_q, byp1_data_d, byp2_data_q, byp2_data_d;

  imm_type_e       imm_type;
  logic [31:0]     imm;
  logic            ex_valid;
  logic            if_ready;
  logic            accept;

  imm_gen u_imm_gen (
    .instr_i    (bus.if_instr),
    .imm_type_o (imm_type),
    .imm_o      (imm)
  );

  // Only REG and FENCE are legal without an immediate format.
  always_comb begin
    dec_in          = '0;
    dec_in.rs1      = bus.if_instr[19:15];
    dec_in.rs2      = bus.if_instr[24:20];
    dec_in.rd       = bus.if_instr[11:7];
    dec_in.opcode   = bus.if_instr[6:0];
    dec_in.funct3   = bus.if_instr[14:12];
    dec_in.funct7b5 = bus.if_instr[30];
    dec_in.imm      = imm;
    dec_in.illegal  = (imm_type == IMM_NONE) && (bus.if_instr[6:0] != OP_REG) &&
                      (bus.if_instr[6:0] != OP_FENCE);
  end

  assign ex_valid = (state_q == StFull);
  assign if_ready = !ex_valid || bus.ex_ready || flush;
  assign accept   = bus.if_valid && if_ready && !flush;

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    pc_d    = pc_q;
    if (flush) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d = StFull;
      dec_d   = dec_in;
      pc_d    = bus.if_pc;
    end else if (bus.ex_ready) begin
      state_d = StEmpty;
    end
  end

  // While stalled the held sources are re-read so later writebacks become visible.
  always_comb begin
    rf_a1 = accept ? bus.if_instr[19:15] : dec_q.rs1;
    rf_a2 = accept ? bus.if_instr[24:20] : dec_q.rs2;
  end

  // The register file returns the pre-write value when read and write share an edge.
  always_comb begin
    byp1_hit_d  = wb_we && (wb_rd != 5'd0) && (wb_rd == rf_a1);
    byp2_hit_d  = wb_we && (wb_rd != 5'd0) && (wb_rd == rf_a2);
    byp1_data_d = wb_wd;
    byp2_data_d = wb_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      dec_q       <= '0;
      pc_q        <= RESET_PC_VAL;
      byp1_hit_q  <= 1'b0;
      byp2_hit_q  <= 1'b0;
      byp1_data_q <= '0;
      byp2_data_q <= '0;
    end else begin
      state_q     <= state_d;
      dec_q       <= dec_d;
      pc_q        <= pc_d;
      byp1_hit_q  <= byp1_hit_d;
      byp2_hit_q  <= byp2_hit_d;
      byp1_data_q <= byp1_data_d;
      byp2_data_q <= byp2_data_d;
    end
  end

  always_comb begin
    bus.if_ready    = if_ready;
    bus.ex_valid    = ex_valid;
    bus.ex_pc       = pc_q;
    bus.ex_imm      = XLEN'(signed'(dec_q.imm));
    bus.ex_rd       = dec_q.rd;
    bus.ex_opcode   = dec_q.opcode;
    bus.ex_funct3   = dec_q.funct3;
    bus.ex_funct7b5 = dec_q.funct7b5;
    bus.ex_illegal  = dec_q.illegal;
    bus.ex_rs1_val  = '0;
    bus.ex_rs2_val  = '0;
    if (ex_valid) begin
      bus.ex_rs1_val = byp1_hit_q ? byp1_data_q : rf_rd1;
      bus.ex_rs2_val = byp2_hit_q ? byp2_data_q : rf_rd2;
    end
  end

endmodule
